// File: rtl/wvb_dpram_xfer_pkg.sv
// ---------------------------------------------------------------------------
// wvb_dpram_xfer_pkg
// Shared constants for the waveform-buffer transfer stage:
//   - FSM state encoding (S_IDLE, S_HOST, S_RELEASE)
//   - err_flags bit indices and width
//   - helper that clamps a requested page length to the DPRAM depth
// Optional feature macro: WVB_DPRAM_XFER_TIMEOUT_EN adds the host-timeout
// flag, which widens err_flags from 3 to 4 bits.
// ---------------------------------------------------------------------------
package wvb_dpram_xfer_pkg;

  // FSM encoding, kept as plain constants for compatibility with older tools
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOST    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Sticky error flag bit positions
  localparam int ERR_RUN_BUSY  = 0;
  localparam int ERR_WR_BUSY   = 1;
  localparam int ERR_LEN_CLAMP = 2;
`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
  localparam int ERR_HOST_TMO  = 3;
  localparam int ERR_W         = 4;
`else
  localparam int ERR_W         = 3;
`endif

  // Page length limited to the number of words the DPRAM can hold
  function automatic logic [15:0] clamp_len(input logic [15:0] req,
                                            input logic [16:0] depth);
    logic [15:0] res;
    if ({1'b0, req} > depth) begin
      res = depth[15:0];
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/wvb_sdp_ram.sv
// ---------------------------------------------------------------------------
// wvb_sdp_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output (address at cycle N, data at N+1). Contents are never cleared and
// the read register has no reset, so it maps onto block RAM.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, one cycle after raddr
// ---------------------------------------------------------------------------
module wvb_sdp_ram #(
  parameter int P_ADR_WIDTH  = 10,
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [P_ADR_WIDTH-1:0]  waddr,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  input  logic [P_ADR_WIDTH-1:0]  raddr,
  output logic [P_DATA_WIDTH-1:0] rdata
);

  logic [P_DATA_WIDTH-1:0] mem [2**P_ADR_WIDTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; a same-address write returns the old word
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wvb_dpram_xfer.sv
// ---------------------------------------------------------------------------
// wvb_dpram_xfer
// Downstream stage of the waveform-buffer reader. The reader fills the
// transfer DPRAM while busy is low and pulses run with the page length;
// the page is then owned by the host (busy/host_rdy high) until host_done,
// after which busy stays low for at least one cycle before the next page.
// Optional feature macro: WVB_DPRAM_XFER_TIMEOUT_EN -- when defined, a page
// the host has not acknowledged within P_TIMEOUT_CYCLES is reclaimed and
// err_flags[3] is set (xfer_cnt is not advanced).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_data/wr_addr/wr_en reader write port (ignored while busy)
//   run, len              page complete pulse and its length in words
//   busy                  DPRAM owned by the host side
//   mode, cfg_mode        host paging mode, registered towards the reader
//   host_rd_addr/_data    host read port, 1-cycle latency, any state
//   host_len, host_rdy    latched (clamped) page length, page available
//   host_done             host finished reading the page
//   xfer_cnt              completed transfers, wraps
//   err_flags, err_clr    sticky errors and their clear
// ---------------------------------------------------------------------------
module wvb_dpram_xfer
  import wvb_dpram_xfer_pkg::*;
#(
  parameter int P_ADR_WIDTH      = 10,
  parameter int P_DATA_WIDTH     = 32,
  parameter int P_TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_DATA_WIDTH-1:0] wr_data,
  input  logic [P_ADR_WIDTH-1:0]  wr_addr,
  input  logic                    wr_en,
  input  logic                    run,
  input  logic [15:0]             len,
  output logic                    busy,
  output logic                    mode,
  input  logic                    cfg_mode,
  input  logic [P_ADR_WIDTH-1:0]  host_rd_addr,
  output logic [P_DATA_WIDTH-1:0] host_rd_data,
  output logic [15:0]             host_len,
  output logic                    host_rdy,
  input  logic                    host_done,
  output logic [15:0]             xfer_cnt,
  output logic [ERR_W-1:0]        err_flags,
  input  logic                    err_clr
);

  localparam logic [16:0] DEPTH = 17'(2**P_ADR_WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             done_hit;
  logic [ERR_W-1:0] err_set;
  logic             ram_we;

`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
  localparam int              TMO_W    = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // The reader may only write while the page is not owned by the host
  assign ram_we = wr_en & ~busy;

  wvb_sdp_ram #(
    .P_ADR_WIDTH  (P_ADR_WIDTH),
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (host_rd_addr),
    .rdata (host_rd_data)
  );

  // Next-state and error-event decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_hit  = 1'b0;
    err_set   = {ERR_W{1'b0}};
    case (state)
      // S_RELEASE accepts a new page exactly like S_IDLE; its only job is
      // to guarantee one low cycle of busy between pages.
      S_IDLE, S_RELEASE: begin
        if (run) begin
          state_nxt = S_HOST;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HOST: begin
        err_set[ERR_RUN_BUSY] = run;
        err_set[ERR_WR_BUSY]  = wr_en;
        if (host_done) begin
          state_nxt = S_RELEASE;
          done_hit  = 1'b1;
        end
`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_nxt             = S_RELEASE;
          err_set[ERR_HOST_TMO] = 1'b1;
        end
`endif
        else begin
          state_nxt = S_HOST;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    err_set[ERR_LEN_CLAMP] = accept & ({1'b0, len} > DEPTH);
  end

  // State, handshake outputs, page length, transfer count and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      host_rdy  <= 1'b0;
      host_len  <= 16'd0;
      xfer_cnt  <= 16'd0;
      err_flags <= {ERR_W{1'b0}};
      mode      <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == S_HOST);
      host_rdy <= (state_nxt == S_HOST);
      mode     <= cfg_mode;
      if (accept) begin
        host_len <= clamp_len(len, DEPTH);
      end
      if (done_hit) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      // A new error in the same cycle as err_clr keeps its flag set
      err_flags <= (err_clr ? {ERR_W{1'b0}} : err_flags) | err_set;
    end
  end

`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
  // Host-ack timer: counts cycles spent in S_HOST, zero on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= {TMO_W{1'b0}};
    end else if ((state == S_HOST) && (state_nxt == S_HOST)) begin
      tmo_cnt <= tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt <= {TMO_W{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_wvb_dpram_xfer.sv
// ---------------------------------------------------------------------------
// tb_wvb_dpram_xfer
// Directed table of cycles with hand-derived expectations, a few multi-cycle
// sequences (reset while host owns the page, optional host timeout), then a
// randomized run compared against a page-ownership model of the block.
// ---------------------------------------------------------------------------
module tb_wvb_dpram_xfer;
  import wvb_dpram_xfer_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << AW;
`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          run;
  logic [15:0]   len;
  logic          busy;
  logic          mode;
  logic          cfg_mode;
  logic [AW-1:0] host_rd_addr;
  logic [DW-1:0] host_rd_data;
  logic [15:0]   host_len;
  logic          host_rdy;
  logic          host_done;
  logic [15:0]   xfer_cnt;
  logic [ERR_W-1:0] err_flags;
  logic          err_clr;

  wvb_dpram_xfer #(
    .P_ADR_WIDTH      (AW),
    .P_DATA_WIDTH     (DW),
    .P_TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .run          (run),
    .len          (len),
    .busy         (busy),
    .mode         (mode),
    .cfg_mode     (cfg_mode),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .host_len     (host_len),
    .host_rdy     (host_rdy),
    .host_done    (host_done),
    .xfer_cnt     (xfer_cnt),
    .err_flags    (err_flags),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the page, plus what the RAM should hold
  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  bit          m_busy;
  logic [15:0] m_hl;
  logic [15:0] m_x;
  logic [3:0]  m_err;
  logic        m_mode;
  int          m_hc;
  logic [31:0] m_rd;
  bit          m_rd_ok;

  int n_vec;
  int n_mis;

  typedef struct {
    logic        run;
    logic [15:0] len;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic        hd;
    logic        clr;
    logic [9:0]  ra;
    logic        cm;
    logic        eb;
    logic [15:0] ehl;
    logic [15:0] ex;
    logic [3:0]  ee;
    logic        rc;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit
  task automatic step(input logic r, input logic [15:0] l, input logic w,
                      input logic [9:0] wa, input logic [31:0] wd, input logic hd,
                      input logic clr, input logic [9:0] ra, input logic cm,
                      input logic rs);
    logic [3:0] ne;
    run = r; len = l; wr_en = w; wr_addr = wa; wr_data = wd;
    host_done = hd; err_clr = clr; host_rd_addr = ra; cfg_mode = cm; rst = rs;
    @(posedge clk);
    m_rd_ok = m_val[ra];
    m_rd    = m_mem[ra];
    ne      = 4'd0;
    if (rs) begin
      m_busy = 1'b0; m_hl = 16'd0; m_x = 16'd0; m_err = 4'd0; m_mode = 1'b0; m_hc = 0;
    end else begin
      if (!m_busy) begin
        if (w) begin
          m_mem[wa] = wd;
          m_val[wa] = 1'b1;
        end
        if (r) begin
          m_busy = 1'b1;
          m_hc   = 0;
          if (int'(l) > DEPTH) begin
            m_hl  = 16'(DEPTH);
            ne[2] = 1'b1;
          end else begin
            m_hl = l;
          end
        end
      end else begin
        if (r) ne[0] = 1'b1;
        if (w) ne[1] = 1'b1;
        if (hd) begin
          m_busy = 1'b0;
          m_x    = m_x + 16'd1;
        end else if (TMO_ON && (m_hc == TMO - 1)) begin
          m_busy = 1'b0;
          ne[3]  = 1'b1;
        end else begin
          m_hc++;
        end
      end
      m_err  = (clr ? 4'd0 : m_err) | ne;
      m_mode = cm;
    end
    #1;
    run = 1'b0; wr_en = 1'b0; host_done = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input logic [9:0] ra);
    step(1'b0, 16'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, ra, 1'b0, 1'b0);
  endtask

  task automatic chk_model();
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_host_rdy", 32'(host_rdy), 32'(m_busy));
    chk("m_host_len", 32'(host_len), 32'(m_hl));
    chk("m_xfer_cnt", 32'(xfer_cnt), 32'(m_x));
    chk("m_err_flags", 32'(err_flags), 32'(m_err[ERR_W-1:0]));
    chk("m_mode", 32'(mode), 32'(m_mode));
    if (m_rd_ok) chk("m_rd_data", host_rd_data, m_rd);
  endtask

  initial begin
    int cnt;
    logic r, w, hd, clr, cm, rs;
    logic [15:0] l;
    logic [9:0] wa, ra;
    n_vec = 0; n_mis = 0;
    m_busy = 1'b0; m_hl = 16'd0; m_x = 16'd0; m_err = 4'd0; m_mode = 1'b0; m_hc = 0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    run = 1'b0; len = 16'd0; wr_en = 1'b0; wr_addr = '0; wr_data = 32'd0;
    host_done = 1'b0; err_clr = 1'b0; host_rd_addr = '0; cfg_mode = 1'b0; rst = 1'b1;

    // run,len, we,wa,wd, hd,clr, ra,cm | busy,host_len,xfer,err, rd_chk,rd
    tbl[0]  = '{1'b0, 16'd0,    1'b1, 10'd0, 32'hA0,   1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0,    16'd0, 4'b0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 16'd0,    1'b1, 10'd1, 32'hA1,   1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 16'd0,    16'd0, 4'b0000, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 16'd0,    1'b1, 10'd2, 32'hA2,   1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0,    16'd0, 4'b0000, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 16'd0,    1'b1, 10'd3, 32'hA3,   1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 16'd0,    16'd0, 4'b0000, 1'b1, 32'hA0};
    tbl[4]  = '{1'b1, 16'd4,    1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd1, 1'b1, 1'b1, 16'd4,    16'd0, 4'b0000, 1'b1, 32'hA1};
    tbl[5]  = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd2, 1'b0, 1'b1, 16'd4,    16'd0, 4'b0000, 1'b1, 32'hA2};
    tbl[6]  = '{1'b1, 16'd7,    1'b1, 10'd0, 32'hFFFF, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 16'd4,    16'd0, 4'b0011, 1'b1, 32'hA0};
    tbl[7]  = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 16'd4,    16'd0, 4'b0011, 1'b1, 32'hA0};
    tbl[8]  = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b0, 1'b1, 10'd3, 1'b1, 1'b1, 16'd4,    16'd0, 4'b0000, 1'b1, 32'hA3};
    tbl[9]  = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd4,    16'd1, 4'b0000, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 16'd2000, 1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 16'd1024, 16'd1, 4'b0100, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 16'd1024, 16'd2, 4'b0100, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 16'd1024, 16'd2, 4'b0000, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 16'd0,    1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 16'd0,    16'd2, 4'b0000, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 16'd9,    1'b0, 10'd0, 32'h0,    1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 16'd0,    16'd3, 4'b0001, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 16'd5,    1'b0, 10'd0, 32'h0,    1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 16'd5,    16'd3, 4'b0001, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 16'd0,    1'b1, 10'd5, 32'h55,   1'b0, 1'b1, 10'd0, 1'b1, 1'b1, 16'd5,    16'd3, 4'b0010, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 16'd0,    1'b0, 10'd0, 32'h0,    1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 16'd5,    16'd4, 4'b0000, 1'b0, 32'h0};

    // Reset values
    step(1'b0, 16'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_host_rdy", 32'(host_rdy), 32'd0);
    chk("rst_host_len", 32'(host_len), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_err_flags", 32'(err_flags), 32'd0);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].run, tbl[i].len, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].hd,
           tbl[i].clr, tbl[i].ra, tbl[i].cm, 1'b0);
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("t%0d_host_rdy", i), 32'(host_rdy), 32'(tbl[i].eb));
      chk($sformatf("t%0d_host_len", i), 32'(host_len), 32'(tbl[i].ehl));
      chk($sformatf("t%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].ex));
      chk($sformatf("t%0d_err_flags", i), 32'(err_flags), 32'(tbl[i].ee[ERR_W-1:0]));
      chk($sformatf("t%0d_mode", i), 32'(mode), 32'(tbl[i].cm));
      if (tbl[i].rc) chk($sformatf("t%0d_rd_data", i), host_rd_data, tbl[i].erd);
    end

    // Reset while the host owns a page: page dropped, RAM kept
    step(1'b1, 16'd3, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("rh_busy_before", 32'(busy), 32'd1);
    step(1'b0, 16'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
    chk("rh_busy", 32'(busy), 32'd0);
    chk("rh_host_rdy", 32'(host_rdy), 32'd0);
    chk("rh_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rh_host_len", 32'(host_len), 32'd0);
    idle(10'd1);
    chk("rh_rd_addr1", host_rd_data, 32'hA1);
    idle(10'd3);
    chk("rh_rd_addr3", host_rd_data, 32'hA3);

`ifdef WVB_DPRAM_XFER_TIMEOUT_EN
    // Host never acknowledges: page reclaimed after TMO cycles of busy
    step(1'b1, 16'd1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      idle(10'd0);
      if (!busy) break;
      cnt++;
    end
    chk("tmo_busy_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_err3", 32'(err_flags[ERR_HOST_TMO]), 32'd1);
    chk("tmo_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(7) == 0);
      l   = ($urandom_range(9) == 0) ? 16'($urandom_range(65535)) : 16'($urandom_range(40));
      w   = 1'($urandom_range(1));
      wa  = ($urandom_range(7) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(15));
      hd  = ($urandom_range(5) == 0);
      clr = ($urandom_range(15) == 0);
      ra  = 10'($urandom_range(15));
      cm  = 1'($urandom_range(1));
      rs  = ($urandom_range(199) == 0);
      if (rs) w = 1'b0;
      step(r, l, w, wa, $urandom, hd, clr, ra, cm, rs);
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
